nios_qsys_debug_scan_master: RTL and testbench

//  On-chip initiator for the Nios II debug slave's virtual-JTAG interface: drives tck/tdi, ir_in and
//  the virtual state strobes (uir/cdr/sdr/udr/rti) exactly as the SLD hub would, and captures tdo.

---
 rtl/nios_qsys_debug_scan_pkg.sv | 19 +
 rtl/nios_qsys_debug_scan_tckgen.sv | 53 +++++
 rtl/nios_qsys_debug_scan_master.sv | 184 ++++++++++++++++++
 tb/tb_nios_qsys_debug_scan_master.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_qsys_debug_scan_pkg.sv
// Shared definitions for the debug-slave virtual-JTAG scan master.
//  - Default DR/IR widths that match the Nios II debug slave.
//  - Scan FSM state encoding, shared by the top and by anyone decoding it.
package nios_qsys_debug_scan_pkg;

    localparam int DR_LEN_DEF = 38;
    localparam int IR_LEN_DEF = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_UIR  = 3'd1;
    localparam state_t ST_CDR  = 3'd2;
    localparam state_t ST_SDR  = 3'd3;
    localparam state_t ST_UDR  = 3'd4;
    localparam state_t ST_RTI  = 3'd5;
    localparam state_t ST_RESP = 3'd6;

endpackage

// File: rtl/nios_qsys_debug_scan_tckgen.sv
// Virtual tck generator.
//  Ports:
//   clk, reset_n  system clock, async active-low reset
//   en            run tck; when low tck is held 0 and the generator re-arms
//   tck           registered virtual tck (low phase first)
//   tck_fall      high on the clk edge that starts a tck period (tck -> 0)
//   tck_rise      high on the clk edge where tck goes 1
//  The first enabled edge is a period start even though tck is already low,
//  so the consumer sees a tck_fall at the very beginning of every run.
module nios_qsys_debug_scan_tckgen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tck,
    output logic tck_fall,
    output logic tck_rise
);

    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TCK_DIV - 1);

    logic [CW-1:0] half_cnt;
    logic          running;
    logic          half_tc;

    assign half_tc  = (half_cnt == '0);
    assign tck_fall = en && half_tc && (tck || !running);
    assign tck_rise = en && half_tc && running && !tck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_cnt <= '0;
            tck      <= 1'b0;
            running  <= 1'b0;
        end else if (!en) begin
            half_cnt <= '0;
            tck      <= 1'b0;
            running  <= 1'b0;
        end else if (tck_fall) begin
            tck      <= 1'b0;
            running  <= 1'b1;
            half_cnt <= RELOAD;
        end else if (tck_rise) begin
            tck      <= 1'b1;
            half_cnt <= RELOAD;
        end else begin
            half_cnt <= half_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/nios_qsys_debug_scan_master.sv
// On-chip virtual-JTAG initiator for the Nios II debug slave.
// Runs an optional UIR then a CDR/SDR/UDR/RTI sequence per command and
// returns the captured tdo bits and the slave's ir_out.
//  Ports:
//   clk, reset_n                     system clock, async active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_ir_en, cmd_ir, cmd_dr        command: optional IR update, DR shift data (bit 0 first)
//   rsp_valid/rsp_ready              response handshake
//   rsp_dr, rsp_ir_out               captured tdo bits, ir_out sampled in CDR
//   vj_tck, vj_tdi, vj_tdo           virtual JTAG serial interface
//   vj_ir_in, vj_ir_out              virtual IR to / status IR from the slave
//   vj_uir/cdr/sdr/udr/rti           virtual state strobes
//
// state | meaning
// IDLE  | tck parked low, rti=1, waiting for a command (or for the first tck period after accept)
// UIR   | one tck period, ir_in updated, uir=1
// CDR   | one tck period, cdr=1, ir_out sampled at tck rise
// SDR   | DR_LEN tck periods, tdi = cmd_dr[k], tdo shifted into rsp_dr at each rise
// UDR   | one tck period, udr=1, tdi=0
// RTI   | RTI_TCKS tck periods, rti=1
// RESP  | tck parked low, rsp_valid=1 until rsp_ready
module nios_qsys_debug_scan_master
    import nios_qsys_debug_scan_pkg::*;
#(
    parameter int DR_LEN   = DR_LEN_DEF,
    parameter int IR_LEN   = IR_LEN_DEF,
    parameter int TCK_DIV  = 2,
    parameter int RTI_TCKS = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_ir_en,
    input  logic [IR_LEN-1:0] cmd_ir,
    input  logic [DR_LEN-1:0] cmd_dr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_LEN-1:0] rsp_dr,
    output logic [IR_LEN-1:0] rsp_ir_out,
    output logic              vj_tck,
    output logic              vj_tdi,
    input  logic              vj_tdo,
    output logic [IR_LEN-1:0] vj_ir_in,
    input  logic [IR_LEN-1:0] vj_ir_out,
    output logic              vj_uir,
    output logic              vj_cdr,
    output logic              vj_sdr,
    output logic              vj_udr,
    output logic              vj_rti
);

    localparam int CNT_MAX = (DR_LEN > RTI_TCKS) ? DR_LEN : RTI_TCKS;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SDR_LOAD = CNT_W'(DR_LEN - 1);
    localparam logic [CNT_W-1:0] RTI_LOAD = CNT_W'(RTI_TCKS - 1);

    state_t            state;
    logic              pend;      // command accepted, first tck period not yet started
    logic              ir_en_q;
    logic [IR_LEN-1:0] ir_q;
    logic [DR_LEN-1:0] dr_sh;
    logic [CNT_W-1:0]  per_cnt;   // tck periods left in SDR/RTI, terminal count at 0
    logic              tck_en;
    logic              tck_fall;
    logic              tck_rise;

    assign tck_en = pend || ((state != ST_IDLE) && (state != ST_RESP));

    nios_qsys_debug_scan_tckgen #(
        .TCK_DIV (TCK_DIV)
    ) u_tckgen (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (tck_en),
        .tck      (vj_tck),
        .tck_fall (tck_fall),
        .tck_rise (tck_rise)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            pend       <= 1'b0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_dr     <= '0;
            rsp_ir_out <= '0;
            vj_tdi     <= 1'b0;
            vj_ir_in   <= '0;
            vj_uir     <= 1'b0;
            vj_cdr     <= 1'b0;
            vj_sdr     <= 1'b0;
            vj_udr     <= 1'b0;
            vj_rti     <= 1'b1;
            ir_en_q    <= 1'b0;
            ir_q       <= '0;
            dr_sh      <= '0;
            per_cnt    <= '0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                cmd_ready <= 1'b0;
                pend      <= 1'b1;
                ir_en_q   <= cmd_ir_en;
                ir_q      <= cmd_ir;
                dr_sh     <= cmd_dr;
            end

            // Slave outputs are sampled with the value present just before tck rises.
            if (tck_rise) begin
                if (state == ST_CDR) rsp_ir_out <= vj_ir_out;
                if (state == ST_SDR) rsp_dr     <= {vj_tdo, rsp_dr[DR_LEN-1:1]};
            end

            if (tck_fall) begin
                case (state)
                    ST_IDLE: begin
                        if (pend) begin
                            pend   <= 1'b0;
                            vj_rti <= 1'b0;
                            if (ir_en_q) begin
                                state    <= ST_UIR;
                                vj_uir   <= 1'b1;
                                vj_ir_in <= ir_q;
                            end else begin
                                state  <= ST_CDR;
                                vj_cdr <= 1'b1;
                            end
                        end
                    end
                    ST_UIR: begin
                        state  <= ST_CDR;
                        vj_uir <= 1'b0;
                        vj_cdr <= 1'b1;
                    end
                    ST_CDR: begin
                        state   <= ST_SDR;
                        vj_cdr  <= 1'b0;
                        vj_sdr  <= 1'b1;
                        vj_tdi  <= dr_sh[0];
                        dr_sh   <= dr_sh >> 1;
                        per_cnt <= SDR_LOAD;
                    end
                    ST_SDR: begin
                        if (per_cnt == '0) begin
                            state  <= ST_UDR;
                            vj_sdr <= 1'b0;
                            vj_udr <= 1'b1;
                            vj_tdi <= 1'b0;
                        end else begin
                            per_cnt <= per_cnt - 1'b1;
                            vj_tdi  <= dr_sh[0];
                            dr_sh   <= dr_sh >> 1;
                        end
                    end
                    ST_UDR: begin
                        state   <= ST_RTI;
                        vj_udr  <= 1'b0;
                        vj_rti  <= 1'b1;
                        per_cnt <= RTI_LOAD;
                    end
                    ST_RTI: begin
                        if (per_cnt == '0) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            per_cnt <= per_cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // cmd_ready stays low on the handshake cycle, so a waiting command
            // is only taken on the following edge.
            if ((state == ST_RESP) && rsp_ready) begin
                state     <= ST_IDLE;
                rsp_valid <= 1'b0;
                cmd_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nios_qsys_debug_scan_master.sv
module tb_nios_qsys_debug_scan_master;

    localparam int DR = 38;
    localparam int IR = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid, cmd_ready, cmd_ir_en, rsp_valid, rsp_ready;
    logic [IR-1:0] cmd_ir, rsp_ir_out, vj_ir_in, vj_ir_out;
    logic [DR-1:0] cmd_dr, rsp_dr;
    logic          vj_tck, vj_tdi, vj_tdo, vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti;

    logic          f_cmd_valid, f_cmd_ready, f_cmd_ir_en, f_rsp_valid, f_rsp_ready;
    logic [IR-1:0] f_cmd_ir, f_rsp_ir_out, f_vj_ir_in, f_vj_ir_out;
    logic [DR-1:0] f_cmd_dr, f_rsp_dr;
    logic          f_vj_tck, f_vj_tdi, f_vj_tdo, f_vj_uir, f_vj_cdr, f_vj_sdr, f_vj_udr, f_vj_rti;

    int tests = 0;
    int fails = 0;
    int uir_cycles = 0;
    int onehot_err = 0;

    always #5 clk = ~clk;

    nios_qsys_debug_scan_master #(.DR_LEN(DR), .IR_LEN(IR), .TCK_DIV(2), .RTI_TCKS(2)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir_en(cmd_ir_en), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .vj_tck(vj_tck), .vj_tdi(vj_tdi), .vj_tdo(vj_tdo), .vj_ir_in(vj_ir_in), .vj_ir_out(vj_ir_out),
        .vj_uir(vj_uir), .vj_cdr(vj_cdr), .vj_sdr(vj_sdr), .vj_udr(vj_udr), .vj_rti(vj_rti)
    );

    nios_qsys_debug_scan_master #(.DR_LEN(DR), .IR_LEN(IR), .TCK_DIV(1), .RTI_TCKS(2)) u_fast (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready), .cmd_ir_en(f_cmd_ir_en), .cmd_ir(f_cmd_ir), .cmd_dr(f_cmd_dr),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_dr(f_rsp_dr), .rsp_ir_out(f_rsp_ir_out),
        .vj_tck(f_vj_tck), .vj_tdi(f_vj_tdi), .vj_tdo(f_vj_tdo), .vj_ir_in(f_vj_ir_in), .vj_ir_out(f_vj_ir_out),
        .vj_uir(f_vj_uir), .vj_cdr(f_vj_cdr), .vj_sdr(f_vj_sdr), .vj_udr(f_vj_udr), .vj_rti(f_vj_rti)
    );

    // Debug-slave model: DR_LEN shift register on tck rise, optional parallel capture in CDR.
    logic [DR-1:0] slv_sr = '0;
    logic          cap_en;
    logic [DR-1:0] cap_val;
    assign vj_tdo = slv_sr[0];
    always @(posedge vj_tck) begin
        if (vj_cdr && cap_en) slv_sr <= cap_val;
        else if (vj_sdr)      slv_sr <= {vj_tdi, slv_sr[DR-1:1]};
    end

    logic [DR-1:0] f_sr = '0;
    logic          f_cap_en;
    logic [DR-1:0] f_cap_val;
    assign f_vj_tdo = f_sr[0];
    always @(posedge f_vj_tck) begin
        if (f_vj_cdr && f_cap_en) f_sr <= f_cap_val;
        else if (f_vj_sdr)        f_sr <= {f_vj_tdi, f_sr[DR-1:1]};
    end

    always @(posedge clk) if (vj_uir) uir_cycles <= uir_cycles + 1;

    always @(negedge clk) begin
        if ($countones({vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti}) != 1) onehot_err <= onehot_err + 1;
        if ($countones({f_vj_uir, f_vj_cdr, f_vj_sdr, f_vj_udr, f_vj_rti}) != 1) onehot_err <= onehot_err + 1;
    end

    typedef struct {
        logic          ir_en;
        logic [IR-1:0] ir;
        logic [DR-1:0] dr;
        logic [IR-1:0] ir_out;
        logic          cap;
        logic [DR-1:0] exp_dr;
        logic [IR-1:0] exp_ir_in;
        int            exp_lat;
    } vec_t;

    vec_t vecs[5];
    localparam logic [DR-1:0] MON_CAP = 38'h06_F56D_F77A;   // MonDReg DEADBEEF at [34:3], low bits 3'b010

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!rsp_valid && n < 400);
    endtask

    task automatic run_vec(input int i);
        int n;
        int u0;
        cap_en     = vecs[i].cap;
        cap_val    = MON_CAP;
        vj_ir_out  = vecs[i].ir_out;
        cmd_ir_en  = vecs[i].ir_en;
        cmd_ir     = vecs[i].ir;
        cmd_dr     = vecs[i].dr;
        n = 0;
        while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        u0 = uir_cycles;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_dr    = ~cmd_dr;
        cmd_ir    = ~cmd_ir;
        cmd_ir_en = ~cmd_ir_en;
        wait_rsp(n);
        chk($sformatf("v%0d_latency", i), 64'(n), 64'(vecs[i].exp_lat));
        chk($sformatf("v%0d_rsp_dr", i), 64'(rsp_dr), 64'(vecs[i].exp_dr));
        chk($sformatf("v%0d_rsp_ir_out", i), 64'(rsp_ir_out), 64'(vecs[i].ir_out));
        chk($sformatf("v%0d_ir_in", i), 64'(vj_ir_in), 64'(vecs[i].exp_ir_in));
        chk($sformatf("v%0d_uir_cycles", i), 64'(uir_cycles - u0), vecs[i].ir_en ? 64'd4 : 64'd0);
        chk($sformatf("v%0d_busy_ready", i), 64'(cmd_ready), 64'd0);
        chk($sformatf("v%0d_idle_pins", i), 64'({vj_tck, vj_rti, vj_tdi}), 64'b010);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_rsp_done", i), 64'({rsp_valid, cmd_ready}), 64'b01);
    endtask

    task automatic run_fast(input logic cap, input logic [DR-1:0] dr, input logic [DR-1:0] exp_dr);
        int n;
        f_cap_en    = cap;
        f_cap_val   = MON_CAP;
        f_vj_ir_out = 2'b10;
        f_cmd_ir_en = 1'b1;
        f_cmd_ir    = 2'b01;
        f_cmd_dr    = dr;
        f_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        f_cmd_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!f_rsp_valid && n < 400);
        chk("fast_latency", 64'(n), 64'd87);
        chk("fast_rsp_dr", 64'(f_rsp_dr), 64'(exp_dr));
        chk("fast_ir", 64'({f_rsp_ir_out, f_vj_ir_in}), 64'b1001);
        f_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        f_rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        vecs[0] = '{1'b1, 2'b01, 38'h2A_5A5A_A5A5, 2'b10, 1'b0, 38'h00_0000_0000, 2'b01, 173};
        vecs[1] = '{1'b0, 2'b10, 38'h15_0F0F_F0F0, 2'b01, 1'b0, 38'h2A_5A5A_A5A5, 2'b01, 169};
        vecs[2] = '{1'b1, 2'b00, 38'h00_0000_0000, 2'b11, 1'b1, MON_CAP,         2'b00, 173};
        vecs[3] = '{1'b1, 2'b11, 38'h3F_FFFF_FFFF, 2'b00, 1'b0, 38'h00_0000_0000, 2'b11, 173};
        vecs[4] = '{1'b0, 2'b01, 38'h00_0000_0001, 2'b01, 1'b0, 38'h3F_FFFF_FFFF, 2'b11, 169};

        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_ir_en = 1'b0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b0;
        vj_ir_out = '0; cap_en = 1'b0; cap_val = '0;
        f_cmd_valid = 1'b0; f_cmd_ir_en = 1'b0; f_cmd_ir = '0; f_cmd_dr = '0; f_rsp_ready = 1'b0;
        f_vj_ir_out = '0; f_cap_en = 1'b0; f_cap_val = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_pins", 64'({vj_tck, vj_tdi, vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti, vj_ir_in, rsp_valid, cmd_ready}),
            64'b000000100_01);
        chk("reset_rsp", 64'({rsp_ir_out, rsp_dr}), 64'd0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Backpressure: response held 50 clk while a second command waits.
        cap_en = 1'b0; vj_ir_out = 2'b11;
        cmd_ir_en = 1'b1; cmd_ir = 2'b10; cmd_dr = 38'h12_3456_789A;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_rsp(n);
        chk("bp_first_latency", 64'(n), 64'd173);
        cmd_ir_en = 1'b0; cmd_ir = 2'b01; cmd_dr = 38'h0A_BCDE_F012; cmd_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_dr !== 38'h00_0000_0001) bad++;
        end
        chk("bp_stall_stable", 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("bp_ready_after_hs", 64'({rsp_valid, cmd_ready}), 64'b01);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("bp_second_accepted", 64'(cmd_ready), 64'd0);
        wait_rsp(n);
        chk("bp_second_latency", 64'(n), 64'd169);
        chk("bp_second_rsp_dr", 64'(rsp_dr), 64'(38'h12_3456_789A));
        chk("bp_second_ir_in", 64'(vj_ir_in), 64'b10);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Reset in the middle of SDR (around bit 20).
        cmd_ir_en = 1'b1; cmd_ir = 2'b11; cmd_dr = 38'h3C_3C3C_3C3C; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!vj_sdr && n < 100) begin @(negedge clk); n++; end
        chk("rst_sdr_reached", 64'(vj_sdr), 64'd1);
        repeat (81) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_pins", 64'({vj_tck, vj_tdi, vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti, vj_ir_in, rsp_valid, cmd_ready}),
            64'b000000100_01);
        chk("rst_mid_rsp", 64'({rsp_ir_out, rsp_dr}), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || vj_tck !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        chk("rst_no_response", 64'(bad), 64'd0);
        run_vec(2);

        // TCK_DIV=1 instance: capture then loopback.
        run_fast(1'b1, 38'h2A_5A5A_A5A5, MON_CAP);
        run_fast(1'b0, 38'h00_0000_0000, 38'h2A_5A5A_A5A5);

        chk("strobe_onehot", 64'(onehot_err), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
